// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the toy data-memory slice.
package toy_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } dmem_state_t;

    localparam logic DRW_READ    = 1'b0;
    localparam logic DRW_WRITE   = 1'b1;
    localparam logic DREQ_ACTIVE = 1'b0;

    localparam int   CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with one write enable and a registered read port.
// Only the read register is reset; the storage itself keeps its contents across reset.
module dmem_array
    import toy_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Holds its value until the next read so the pipeline sees stable data.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: captures one request, waits WAIT_CYC cycles, then acks.
// Optional misalignment flag DERR is built when DMEM_ALIGN_CHECK_EN is defined.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready; a low DREQ is captured on the next rising edge
//   WAIT  | counting down wait states on the captured request
//   ACK   | access done; DACK (and DERR if misaligned) high one cycle
module dmem_responder
    import toy_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [31:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        DSTALL,
    output logic        DACK
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        DERR
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    dmem_state_t           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  drw_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  mis_q;
    logic                  dack_q;
    logic                  derr_q;

    logic                  req_now;
    logic                  addr_mis;
    logic                  acc;
    logic                  acc_drw;
    logic                  acc_mis;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic                  unused_sig;

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_mis = (DADDR[1:0] != 2'b00);
`else
    assign addr_mis = 1'b0;
`endif

    assign req_now = (state_q == IDLE) && (DREQ == DREQ_ACTIVE);

    // The access fires on the edge that enters ACK; with zero wait states that is the capture edge itself.
    assign acc       = (req_now && (WAIT_CYC == 0)) || ((state_q == WAIT) && (cnt_q == CNT_ONE));
    assign acc_drw   = (state_q == IDLE) ? DRW                       : drw_q;
    assign acc_idx   = (state_q == IDLE) ? DADDR[DEPTH_LOG2+1:2]     : idx_q;
    assign acc_wdata = (state_q == IDLE) ? DWDATA                    : wdata_q;
    assign acc_mis   = (state_q == IDLE) ? addr_mis                  : mis_q;

    assign mem_we = acc && (acc_drw == DRW_WRITE) && !acc_mis;
    assign mem_re = acc && (acc_drw == DRW_READ)  && !acc_mis;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drw_q   <= DRW_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            dack_q  <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            dack_q <= 1'b0;
            derr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_now) begin
                        drw_q   <= DRW;
                        idx_q   <= DADDR[DEPTH_LOG2+1:2];
                        wdata_q <= DWDATA;
                        mis_q   <= addr_mis;
                        if (WAIT_CYC == 0) begin
                            state_q <= ACK;
                            cnt_q   <= '0;
                            dack_q  <= 1'b1;
                            derr_q  <= addr_mis;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ACK;
                        dack_q  <= 1'b1;
                        derr_q  <= mis_q;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (DRDATA)
    );

    assign DSTALL = (state_q == WAIT) || req_now;
    assign DACK   = dack_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign DERR = derr_q;
`endif

    assign unused_sig = ^{DADDR, derr_q};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYC = 2, 0, 3) checked against a word-level memory model.
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        dreq_s   [3];
    logic        drw_s    [3];
    logic [31:0] daddr_s  [3];
    logic [31:0] dwdata_s [3];
    logic [31:0] drdata_s [3];
    logic        dstall_s [3];
    logic        dack_s   [3];
`ifdef DMEM_ALIGN_CHECK_EN
    logic        derr_s   [3];
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mm      [3][1024];
    logic [31:0] last_rd [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2 (10),
            .WAIT_CYC   (g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) u_dut (
            .CLK    (CLK),
            .RSTN   (RSTN),
            .DREQ   (dreq_s[g]),
            .DRW    (drw_s[g]),
            .DADDR  (daddr_s[g]),
            .DWDATA (dwdata_s[g]),
            .DRDATA (drdata_s[g]),
            .DSTALL (dstall_s[g]),
            .DACK   (dack_s[g])
`ifdef DMEM_ALIGN_CHECK_EN
            ,
            .DERR   (derr_s[g])
`endif
        );
    end

    function automatic int wc(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic is_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // One complete request on instance i, starting from an IDLE cycle at posedge+1 and
    // returning at posedge+1 of the IDLE cycle after ACK.
    task automatic do_req(input int i, input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input string nm);
        int   w;
        int   stalls;
        int   idx;
        logic mis;
        w      = wc(i);
        stalls = 0;
        idx    = int'((a / 32'd4) % 32'd1024);
        mis    = is_mis(a);
        dreq_s[i]   = 1'b0;
        drw_s[i]    = rw;
        daddr_s[i]  = a;
        dwdata_s[i] = wd;
        @(negedge CLK);
        if (dstall_s[i] === 1'b1) stalls++;
        checks++;
        if (dack_s[i] !== 1'b0) begin
            failures++;
            $display("FAIL %s pre-capture DACK: got %b expected 0", nm, dack_s[i]);
        end
        @(posedge CLK);
        for (int k = 1; k <= w + 1; k++) begin
            #1;
            if (k <= w) begin
                dreq_s[i]   = 1'($urandom);
                drw_s[i]    = 1'($urandom);
                daddr_s[i]  = $urandom;
                dwdata_s[i] = $urandom;
            end else begin
                dreq_s[i] = 1'b1;
            end
            @(negedge CLK);
            if (k == w + 1 && !mis) begin
                if (rw) mm[i][idx] = wd;
                else    last_rd[i] = mm[i][idx];
            end
            if (dstall_s[i] === 1'b1) stalls++;
            checks++;
            if (dack_s[i] !== (k == w + 1)) begin
                failures++;
                $display("FAIL %s DACK cycle %0d: got %b expected %b", nm, k, dack_s[i], (k == w + 1));
            end
            checks++;
            if (drdata_s[i] !== last_rd[i]) begin
                failures++;
                $display("FAIL %s DRDATA cycle %0d: got %h expected %h", nm, k, drdata_s[i], last_rd[i]);
            end
`ifdef DMEM_ALIGN_CHECK_EN
            checks++;
            if (derr_s[i] !== (k == w + 1 && mis)) begin
                failures++;
                $display("FAIL %s DERR cycle %0d: got %b expected %b", nm, k, derr_s[i], (k == w + 1 && mis));
            end
`endif
            @(posedge CLK);
        end
        #1;
        checks++;
        if (stalls != w + 1) begin
            failures++;
            $display("FAIL %s DSTALL cycles: got %0d expected %0d", nm, stalls, w + 1);
        end
    endtask

    task automatic check_idle_all(input string nm);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dstall_s[i] !== 1'b0 || dack_s[i] !== 1'b0 || drdata_s[i] !== 32'h0) begin
                failures++;
                $display("FAIL %s inst%0d: got stall=%b ack=%b rdata=%h expected 0/0/0",
                         nm, i, dstall_s[i], dack_s[i], drdata_s[i]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            dreq_s[i] = 1'b1; drw_s[i] = 1'b0; daddr_s[i] = '0; dwdata_s[i] = '0;
            last_rd[i] = '0;
        end
        RSTN = 1'b1;
        #2 RSTN = 1'b0;
        #1;
        check_idle_all("reset_async");
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check_idle_all("idle");
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_write_read();
        do_req(0, 1'b1, 32'h40, 32'hDEADBEEF, "w2_write");
        do_req(0, 1'b0, 32'h40, 32'h0, "w2_read");
        checks++;
        if (drdata_s[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL w2_read_hold: got %h expected deadbeef", drdata_s[0]);
        end
    endtask

    task automatic test_zero_wait();
        do_req(1, 1'b1, 32'h0, 32'h12345678, "w0_write");
        do_req(1, 1'b0, 32'h0, 32'h0, "w0_read");
        checks++;
        if (drdata_s[1] !== 32'h12345678) begin
            failures++;
            $display("FAIL w0_read_hold: got %h expected 12345678", drdata_s[1]);
        end
    endtask

    task automatic test_wrap();
        do_req(0, 1'b1, 32'h1000, 32'hA5A5A5A5, "wrap_write");
        do_req(0, 1'b0, 32'h0, 32'h0, "wrap_read");
        checks++;
        if (drdata_s[0] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL wrap_read_hold: got %h expected a5a5a5a5", drdata_s[0]);
        end
    endtask

    task automatic test_reset_abort();
        do_req(2, 1'b1, 32'h8, 32'hCAFE0008, "abort_pre");
        dreq_s[2] = 1'b0; drw_s[2] = 1'b1; daddr_s[2] = 32'h8; dwdata_s[2] = 32'h1;
        @(posedge CLK);
        #1 dreq_s[2] = 1'b1;
        @(posedge CLK);
        #1 RSTN = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        check_idle_all("abort_in_reset");
        RSTN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            checks++;
            if (dack_s[2] !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_ack cycle %0d: got %b expected 0", c, dack_s[2]);
            end
        end
        @(posedge CLK);
        #1;
        do_req(2, 1'b0, 32'h8, 32'h0, "abort_read");
        checks++;
        if (drdata_s[2] !== 32'hCAFE0008) begin
            failures++;
            $display("FAIL abort_read_hold: got %h expected cafe0008", drdata_s[2]);
        end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_align();
        logic [31:0] before;
        before = drdata_s[0];
        do_req(0, 1'b0, 32'h42, 32'h0, "align_read");
        checks++;
        if (drdata_s[0] !== before) begin
            failures++;
            $display("FAIL align_read_hold: got %h expected %h", drdata_s[0], before);
        end
        do_req(0, 1'b1, 32'h43, 32'hFFFFFFFF, "align_write");
        do_req(0, 1'b0, 32'h40, 32'h0, "align_check_read");
        checks++;
        if (drdata_s[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL align_array_unchanged: got %h expected deadbeef", drdata_s[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] addrs [8];
        int          pick;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) begin
                addrs[n] = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
                addrs[n][1:0] = 2'b00;
`endif
                do_req(i, 1'b1, addrs[n], $urandom, "rand_fill");
            end
            for (int n = 0; n < 12; n++) begin
                pick = int'($urandom_range(7, 0));
                do_req(i, 1'($urandom), addrs[pick], $urandom, "rand_op");
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_read();
        test_zero_wait();
        test_wrap();
        test_reset_abort();
`ifdef DMEM_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
